// File: rtl/period_to_freq_pkg.sv
// Shared types and constants for the period-to-frequency converter.
// Package freq_pkg: divider state encoding, data widths, numerator helper.
package freq_pkg;

  localparam int CNT_W  = 30;
  localparam int FREQ_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // CLK_HZ * N, truncated to the 32-bit numerator the divider consumes.
  function automatic logic [FREQ_W-1:0] numerator(input longint clk_hz, input longint n);
    longint prod;
    prod = clk_hz * n;
    return prod[FREQ_W-1:0];
  endfunction

endpackage

// File: rtl/period_to_freq_if.sv
// Sample stream in, frequency result and status out.
// slave = converter side, master = producer/consumer side.
interface period_to_freq_if;
  import freq_pkg::*;

  logic [CNT_W-1:0]  cycle_count;
  logic              valid;
  logic [FREQ_W-1:0] freq_hz;
  logic              freq_valid;
  logic              busy;
  logic              overrun;

  modport slave (
    input  cycle_count, valid,
    output freq_hz, freq_valid, busy, overrun
  );

  modport master (
    output cycle_count, valid,
    input  freq_hz, freq_valid, busy, overrun
  );

endinterface

// File: rtl/period_to_freq_seq_divider.sv
// Generic radix-2 restoring divider, one quotient bit per cycle, MSB first.
// start is honoured only in IDLE; done is a one-cycle strobe with quotient already registered.
module seq_divider
  import freq_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic         busy,
  output logic         done
);

  localparam int ITER_W = $clog2(W);

  div_state_t        state, state_nxt;
  logic [W-1:0]      num;
  logic [W-1:0]      den;
  logic [W-1:0]      rem;
  logic [W-1:0]      quo;
  logic [ITER_W-1:0] iter;
  logic [W:0]        shifted;
  logic [W:0]        diff;
  logic              fits;

  always_comb begin
    shifted = {rem, num[W-1]};
    diff    = shifted - {1'b0, den};
    fits    = ~diff[W];
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = DIV;
      DIV:     if (iter == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      num      <= '0;
      den      <= '0;
      rem      <= '0;
      quo      <= '0;
      iter     <= '0;
      quotient <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            num  <= dividend;
            den  <= divisor;
            rem  <= '0;
            quo  <= '0;
            iter <= ITER_W'(W - 1);
          end
        end
        DIV: begin
          num  <= num << 1;
          rem  <= fits ? diff[W-1:0] : shifted[W-1:0];
          quo  <= {quo[W-2:0], fits};
          iter <= iter - 1'b1;
          // Publish on the last iteration so the word is stable while done is high.
          if (iter == '0) quotient <= {quo[W-2:0], fits};
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: rtl/period_to_freq.sv
// Period (sys_clk counts) to frequency (Hz): optional batch averaging, then sequential division.
// FREQ_AVG_EN: when defined, averages 2^AVG_LOG2 nonzero samples per result; otherwise N = 1.
module period_to_freq
  import freq_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int AVG_LOG2 = 2
) (
  input logic              sys_clk,
  input logic              sys_rst,
  period_to_freq_if.slave  bus
);

`ifdef FREQ_AVG_EN
  localparam int N     = 1 << AVG_LOG2;
  localparam int SUM_W = CNT_W + AVG_LOG2;
`else
  localparam int N     = 1;
  localparam int SUM_W = CNT_W;
`endif
  localparam int DIV_W = (SUM_W > FREQ_W) ? SUM_W : FREQ_W;
  localparam logic [FREQ_W-1:0] NUM = numerator(longint'(CLK_HZ), longint'(N));

  if ((longint'(CLK_HZ) << AVG_LOG2) >= 64'sh1_0000_0000) begin : g_num_overflow
    $error("period_to_freq: CLK_HZ * 2^AVG_LOG2 does not fit in 32 bits");
  end

  logic             accept;
  logic [SUM_W-1:0] batch_sum;
  logic             batch_ready;
  logic             start;
  logic             div_busy;
  logic             div_done;
  logic [DIV_W-1:0] div_quotient;
  logic             overrun;

  assign accept = bus.valid && (bus.cycle_count != '0);

`ifdef FREQ_AVG_EN
  logic [SUM_W-1:0]    acc;
  logic [SUM_W-1:0]    sum_nxt;
  logic [AVG_LOG2-1:0] sample_cnt;

  assign sum_nxt = acc + SUM_W'(bus.cycle_count);

  // The accumulator restarts in the completing cycle, so batching never stalls.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      acc         <= '0;
      sample_cnt  <= '0;
      batch_sum   <= '0;
      batch_ready <= 1'b0;
    end else begin
      batch_ready <= 1'b0;
      if (accept) begin
        if (&sample_cnt) begin
          batch_sum   <= sum_nxt;
          batch_ready <= 1'b1;
          acc         <= '0;
          sample_cnt  <= '0;
        end else begin
          acc        <= sum_nxt;
          sample_cnt <= sample_cnt + 1'b1;
        end
      end
    end
  end
`else
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      batch_sum   <= '0;
      batch_ready <= 1'b0;
    end else begin
      batch_ready <= 1'b0;
      if (accept) begin
        batch_sum   <= bus.cycle_count;
        batch_ready <= 1'b1;
      end
    end
  end
`endif

  // A pending start counts as occupied, otherwise two close batches could both launch.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      start   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      start <= 1'b0;
      if (batch_ready) begin
        if (div_busy || start) overrun <= 1'b1;
        else                   start   <= 1'b1;
      end
    end
  end

  seq_divider #(
    .W (DIV_W)
  ) u_div (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .start    (start),
    .dividend (DIV_W'(NUM)),
    .divisor  (DIV_W'(batch_sum)),
    .quotient (div_quotient),
    .busy     (div_busy),
    .done     (div_done)
  );

  assign bus.freq_hz    = FREQ_W'(div_quotient);
  assign bus.freq_valid = div_done;
  assign bus.busy       = div_busy;
  assign bus.overrun    = overrun;

endmodule
